// File: rtl/lvl_pkg.sv
// Shared level/divisor table and state encoding for the divided-clock
// level decoder and its siblings.
package lvl_pkg;

    localparam int LVL_CNT_W = 29;
    localparam int LVL_CODES = 16;

    typedef logic [3:0] lvl_code_t;
    typedef logic [LVL_CNT_W-1:0] lvl_div_t;

    // Codes 11..14 hold zero; the mask keeps them out.
    localparam lvl_div_t LVL_TABLE [LVL_CODES] = '{
        29'd50000000, 29'd1,        29'd45000000, 29'd40000000,
        29'd35000000, 29'd30000000, 29'd25000000, 29'd20000000,
        29'd15000000, 29'd10000000, 29'd5000000,  29'd0,
        29'd0,        29'd0,        29'd0,        29'd2
    };

    localparam logic [LVL_CODES-1:0] LVL_PRESENT = 16'b1000_0111_1111_1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } lvl_state_e;

endpackage

// File: rtl/clk_level_decoder_if.sv
// Measured clock in, recovered level out.
interface clk_level_decoder_if;

    logic       ClkIn;
    logic [3:0] Level;
    logic       Valid;
    logic       Mismatch;

    modport master (
        output ClkIn,
        input  Level,
        input  Valid,
        input  Mismatch
    );

    modport slave (
        input  ClkIn,
        output Level,
        output Valid,
        output Mismatch
    );

endinterface

// File: rtl/lvl_edge_sync.sv
// Two-flop synchronizer plus a third flop; pulses on either edge of In.
module lvl_edge_sync (
    input  logic Clk,
    input  logic Rst,
    input  logic In,
    output logic Pulse
);

    logic [2:0] sr;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[1:0], In};
        end
    end

    assign Pulse = sr[1] ^ sr[2];

endmodule

// File: rtl/clk_level_decoder.sv
// Recovers the 4-bit level code from the half-period of the divided clock.
module clk_level_decoder
    import lvl_pkg::*;
#(
    parameter int              CNT_W   = LVL_CNT_W,
    parameter int              TOL     = 0,
    parameter int              CONFIRM = 2,
    parameter logic [CNT_W-1:0] TIMEOUT = '1
) (
    input  logic Clk,
    input  logic Rst,
    clk_level_decoder_if.slave Bus
);

    localparam int MW = (CONFIRM < 1) ? 1 : $clog2(CONFIRM + 1);

    logic             edgeP;
    lvl_state_e       state, stateNx;
    logic [CNT_W-1:0] halfCnt, halfNx, divD;
    lvl_code_t        cand, candNx;
    lvl_code_t        levelR, levelNx, code;
    logic [MW-1:0]    matchCnt, matchNx;
    logic             validR, validNx;
    logic             mismR, mismNx;
    logic             hit, tmo;

    lvl_edge_sync uSync (
        .Clk   (Clk),
        .Rst   (Rst),
        .In    (Bus.ClkIn),
        .Pulse (edgeP)
    );

    function automatic logic near(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W-1:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return d <= CNT_W'(TOL);
    endfunction

    // The divider toggles every DivSel+1 cycles, hence the minus one.
    assign divD = halfCnt - CNT_W'(1);
    assign tmo  = (halfCnt == TIMEOUT);

    always_comb begin
        halfNx = halfCnt;
        if (edgeP) begin
            halfNx = CNT_W'(1);
        end else if (!tmo) begin
            halfNx = halfCnt + CNT_W'(1);
        end
    end

    // Descending scan so the lowest matching code wins.
    always_comb begin
        hit  = 1'b0;
        code = '0;
        for (int c = LVL_CODES - 1; c >= 0; c--) begin
            if (LVL_PRESENT[c] &&
                near(divD, CNT_W'(LVL_TABLE[c]))) begin
                hit  = 1'b1;
                code = 4'(c);
            end
        end
    end

    always_comb begin
        stateNx = state;
        candNx  = cand;
        matchNx = matchCnt;
        levelNx = levelR;
        validNx = validR;
        mismNx  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (edgeP) begin
                    stateNx = ST_ACQ;
                    matchNx = '0;
                end
            end
            ST_ACQ: begin
                if (edgeP) begin
                    if (!hit) begin
                        mismNx  = 1'b1;
                        matchNx = '0;
                    end else if (code == cand) begin
                        matchNx = matchCnt + MW'(1);
                        if (int'(matchCnt) + 1 >= CONFIRM) begin
                            stateNx = ST_LOCK;
                            levelNx = code;
                            validNx = 1'b1;
                        end
                    end else begin
                        candNx  = code;
                        matchNx = MW'(1);
                    end
                end else if (tmo) begin
                    mismNx  = 1'b1;
                    validNx = 1'b0;
                    stateNx = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (edgeP) begin
                    if (!hit) begin
                        validNx = 1'b0;
                        mismNx  = 1'b1;
                        matchNx = '0;
                        stateNx = ST_ACQ;
                    end else if (code != levelR) begin
                        validNx = 1'b0;
                        candNx  = code;
                        matchNx = MW'(1);
                        stateNx = ST_ACQ;
                    end
                end else if (tmo) begin
                    mismNx  = 1'b1;
                    validNx = 1'b0;
                    stateNx = ST_IDLE;
                end
            end
            default: begin
                stateNx = ST_IDLE;
                validNx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_IDLE;
            halfCnt  <= '0;
            cand     <= '0;
            matchCnt <= '0;
            levelR   <= '0;
            validR   <= 1'b0;
            mismR    <= 1'b0;
        end else begin
            state    <= stateNx;
            halfCnt  <= halfNx;
            cand     <= candNx;
            matchCnt <= matchNx;
            levelR   <= levelNx;
            validR   <= validNx;
            mismR    <= mismNx;
        end
    end

    assign Bus.Level    = levelR;
    assign Bus.Valid    = validR;
    assign Bus.Mismatch = mismR;

endmodule

// File: tb/tb_clk_level_decoder.sv
// Directed bench for clk_level_decoder: vector table plus
// hand-written level-change, timeout and reset sequences.
module tb_clk_level_decoder;
    import lvl_pkg::*;

    logic Clk   = 1'b0;
    logic Rst   = 1'b1;
    logic clkIn = 1'b0;

    always #5 Clk = ~Clk;

    clk_level_decoder_if busA ();
    clk_level_decoder_if busB ();
    clk_level_decoder_if busC ();

    assign busA.ClkIn = clkIn;
    assign busB.ClkIn = clkIn;
    assign busC.ClkIn = clkIn;

    clk_level_decoder #(.TIMEOUT(29'd64)) dutA (
        .Clk (Clk),
        .Rst (Rst),
        .Bus (busA)
    );

    clk_level_decoder #(.TOL(1), .TIMEOUT(29'd64)) dutB (
        .Clk (Clk),
        .Rst (Rst),
        .Bus (busB)
    );

    clk_level_decoder dutC (
        .Clk (Clk),
        .Rst (Rst),
        .Bus (busC)
    );

    int nCmp  = 0;
    int nBad  = 0;
    int mismA = 0;
    int mismB = 0;

    always @(posedge Clk) begin
        #1;
        if (busA.Mismatch) mismA++;
        if (busB.Mismatch) mismB++;
    end

    typedef struct {
        int dutSel;
        int per;
        int n;
        int expValid;
        int expLevel;
        int expMism;
    } vec_t;

    vec_t vecs [10];

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic runHalves(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            clkIn = ~clkIn;
            cyc(p);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nBad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic doReset();
        Rst   = 1'b1;
        clkIn = 1'b0;
        cyc(3);
        Rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        int base;
        int found;
        int v, l;

        vecs[0] = '{0, 2, 3,  1, 1,  0};
        vecs[1] = '{0, 2, 2,  0, 0,  0};
        vecs[2] = '{0, 3, 3,  1, 15, 0};
        vecs[3] = '{0, 5, 4,  0, 0,  3};
        vecs[4] = '{0, 1, 4,  0, 0,  3};
        vecs[5] = '{0, 2, 10, 1, 1,  0};
        vecs[6] = '{1, 3, 3,  1, 1,  0};
        vecs[7] = '{1, 4, 3,  1, 15, 0};
        vecs[8] = '{1, 5, 4,  0, 0,  3};
        vecs[9] = '{1, 2, 3,  1, 1,  0};

        cyc(3);
        chk("rstA.level", int'(busA.Level), 0);
        chk("rstA.valid", int'(busA.Valid), 0);
        chk("rstA.mism",  int'(busA.Mismatch), 0);
        chk("rstB.level", int'(busB.Level), 0);
        chk("rstB.valid", int'(busB.Valid), 0);
        chk("rstC.valid", int'(busC.Valid), 0);
        chk("rstC.mism",  int'(busC.Mismatch), 0);

        for (int i = 0; i < 10; i++) begin
            doReset();
            base = (vecs[i].dutSel == 0) ? mismA : mismB;
            runHalves(vecs[i].per, vecs[i].n);
            cyc(3);
            v = (vecs[i].dutSel == 0) ? int'(busA.Valid) : int'(busB.Valid);
            l = (vecs[i].dutSel == 0) ? int'(busA.Level) : int'(busB.Level);
            chk($sformatf("vec%0d.valid", i), v, vecs[i].expValid);
            chk($sformatf("vec%0d.level", i), l, vecs[i].expLevel);
            chk($sformatf("vec%0d.mism", i),
                ((vecs[i].dutSel == 0) ? mismA : mismB) - base,
                vecs[i].expMism);
        end

        doReset();
        base = mismA;
        runHalves(2, 6);
        chk("s1.lockValid", int'(busA.Valid), 1);
        chk("s1.lockLevel", int'(busA.Level), 1);
        chk("s1.dfltValid", int'(busC.Valid), 1);
        chk("s1.dfltLevel", int'(busC.Level), 1);
        runHalves(3, 1);
        chk("s1.hold2", int'(busA.Valid), 1);
        runHalves(3, 1);
        chk("s1.dropValid", int'(busA.Valid), 0);
        chk("s1.dropLevel", int'(busA.Level), 1);
        runHalves(3, 1);
        chk("s1.relockValid", int'(busA.Valid), 1);
        chk("s1.relockLevel", int'(busA.Level), 15);
        chk("s1.noMism", mismA - base, 0);

        runHalves(5, 1);
        chk("s2.stillLock", int'(busA.Valid), 1);
        runHalves(5, 1);
        chk("s2.valid", int'(busA.Valid), 0);
        chk("s2.levelHold", int'(busA.Level), 15);
        chk("s2.mism1", mismA - base, 1);
        runHalves(5, 2);
        chk("s2.mism3", mismA - base, 3);
        chk("s2.levelHold2", int'(busA.Level), 15);

        base = mismA;
        runHalves(2, 1);
        runHalves(2, 3);
        chk("s3.lockValid", int'(busA.Valid), 1);
        chk("s3.lockLevel", int'(busA.Level), 1);
        found = -1;
        for (int k = 3; k <= 100; k++) begin
            cyc(1);
            if (busA.Mismatch) begin
                found = k;
                break;
            end
        end
        chk("s3.timeoutCycle", found, 67);
        cyc(10);
        chk("s3.mismCount", mismA - base, 2);
        chk("s3.valid", int'(busA.Valid), 0);
        chk("s3.state", int'(dutA.state), int'(ST_IDLE));
        chk("s3.levelHold", int'(busA.Level), 1);
        runHalves(2, 4);
        cyc(1);
        chk("s3.resumeValid", int'(busA.Valid), 1);
        chk("s3.resumeLevel", int'(busA.Level), 1);

        Rst = 1'b1;
        cyc(1);
        chk("s4.valid", int'(busA.Valid), 0);
        chk("s4.level", int'(busA.Level), 0);
        chk("s4.mism", int'(busA.Mismatch), 0);
        clkIn = 1'b0;
        cyc(3);
        Rst = 1'b0;
        cyc(1);
        runHalves(2, 3);
        chk("s4.notYet", int'(busA.Valid), 0);
        cyc(2);
        chk("s4.relockValid", int'(busA.Valid), 1);
        chk("s4.relockLevel", int'(busA.Level), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nBad);
        $finish;
    end

endmodule
